// File: rtl/paged_ram_ctl.sv
// paged_ram_ctl: zero-page/main RAM behind a req/ack handshake.
//   Addresses below ZP_LIMIT hit the zero-page array, all others hit the main array.
//   Each array is indexed by the low address bits, so upper bits alias.
//   Writes at or above RO_BASE are dropped and flagged with err.
//   Every access takes WAIT extra cycles.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   req, we          request strobe and direction (1 = write), sampled only when idle
//   addr, wdata      byte address and write data, latched with req
//   rdata            read data, updated at the ack edge of a read and held until the next one
//   ack, err         one-cycle completion pulse; err = 1 when a protected write was dropped
//   busy             an access is in progress
module paged_ram_ctl #(
  parameter int unsigned    DW       = 8,
  parameter int unsigned    AW       = 16,
  parameter int unsigned    ZP_AW    = 4,
  parameter int unsigned    MEM_AW   = 4,
  parameter logic [AW-1:0]  ZP_LIMIT = 'h0100,
  parameter logic [AW-1:0]  RO_BASE  = 'hF000,
  parameter int unsigned    WAIT     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          err,
  output logic          busy
);

  if (WAIT > 15) begin : g_bad_wait
    $error("paged_ram_ctl: WAIT must be in 0..15");
  end

  localparam logic [3:0] WaitCnt = 4'(WAIT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  // Storage is deliberately left out of reset so preloaded contents survive it.
  logic [DW-1:0]   zp_mem   [2**ZP_AW];
  logic [DW-1:0]   main_mem [2**MEM_AW];

  logic              zp_sel, ro_sel, zp_we, main_we;
  logic [ZP_AW-1:0]  zp_idx;
  logic [MEM_AW-1:0] main_idx;

  // The zero page wins when the two regions overlap.
  assign zp_sel   = (addr_q < ZP_LIMIT);
  assign ro_sel   = !zp_sel && (addr_q >= RO_BASE);
  assign zp_idx   = addr_q[ZP_AW-1:0];
  assign main_idx = addr_q[MEM_AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    zp_we   = 1'b0;
    main_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WaitCnt;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = StIdle;
          if (we_q) begin
            if (zp_sel)      zp_we   = 1'b1;
            else if (ro_sel) err_d   = 1'b1;
            else             main_we = 1'b1;
          end else begin
            rdata_d = zp_sel ? zp_mem[zp_idx] : main_mem[main_idx];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the access edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst_n && zp_we)   zp_mem[zp_idx]     <= wdata_q;
    if (rst_n && main_we) main_mem[main_idx] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q == StBusy);

endmodule

// File: tb/tb_paged_ram_ctl.sv
// Bench for paged_ram_ctl: three instances with WAIT = 0, 3 and 5, checked against a
// word-level model of both arrays.
module tb_paged_ram_ctl;

  logic        clk;
  logic        rst_n [3];
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [7:0]  wdata [3];
  logic [7:0]  rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  int          wait_of [3] = '{0, 3, 5};
  logic [7:0]  m_zp    [3][16];
  logic [7:0]  m_main  [3][16];
  logic [7:0]  m_rd    [3];

  paged_ram_ctl #(.WAIT(0)) u_d0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );
  paged_ram_ctl #(.WAIT(3)) u_d1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );
  paged_ram_ctl #(.WAIT(5)) u_d2 (
    .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Model: zero page below 0x0100, write-protect from 0xF000, both arrays 16 words.
  task automatic model(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                       output logic [7:0] exp_rd, output logic exp_err);
    int i;
    i = int'(a % 16);
    exp_err = 1'b0;
    if (a < 16'h0100) begin
      if (w) m_zp[d][i] = wd;
      else   m_rd[d] = m_zp[d][i];
    end else if (w) begin
      if (a >= 16'hF000) exp_err = 1'b1;
      else               m_main[d][i] = wd;
    end else begin
      m_rd[d] = m_main[d][i];
    end
    exp_rd = m_rd[d];
  endtask

  // One access. b2b=1 drives req at the current negedge (expected to be an ack cycle).
  // lat counts edges from the accepting edge to the edge that raised ack.
  task automatic access(input int d, input bit b2b, input logic w, input logic [15:0] a,
                        input logic [7:0] wd, output logic [7:0] rd, output logic e,
                        output logic b1, output int lat);
    if (!b2b) @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    req[d] = 1'b0;
    b1  = busy[d];
    lat = 0;
    while (!ack[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata[d];
    e  = err[d];
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 3; d++) begin
        m_zp[d][i]   = 8'($urandom);
        m_main[d][i] = 8'($urandom);
      end
      m_main[0][3] = 8'hA5;
      u_d0.zp_mem[i] = m_zp[0][i]; u_d0.main_mem[i] = m_main[0][i];
      u_d1.zp_mem[i] = m_zp[1][i]; u_d1.main_mem[i] = m_main[1][i];
      u_d2.zp_mem[i] = m_zp[2][i]; u_d2.main_mem[i] = m_main[2][i];
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd, erd; logic e, ee, b1; int lat;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b1; we[d] = 1'b0; addr[d] = 16'h0203; wdata[d] = 8'h00;
      m_rd[d] = 8'h00;
    end
    preload();
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({ack[d], err[d], busy[d], rdata[d]} !== 11'b0) begin
          errors++;
          $display("FAIL reset_outputs d=%0d got ack=%b err=%b busy=%b rdata=%h want all 0",
                   d, ack[d], err[d], busy[d], rdata[d]);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; rst_n[d] = 1'b1;
    end
    access(0, 0, 1'b0, 16'h0203, 8'h00, rd, e, b1, lat);
    model(0, 1'b0, 16'h0203, 8'h00, erd, ee);
    checks++;
    if (rd !== 8'hA5) begin
      errors++;
      $display("FAIL preload_survives got %h want a5", rd);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd, erd; logic e, ee, b1; int lat;
    access(0, 0, 1'b1, 16'h0005, 8'h3C, rd, e, b1, lat);
    model(0, 1'b1, 16'h0005, 8'h3C, erd, ee);
    checks++;
    if ({b1, e} !== 2'b10 || lat != 1) begin
      errors++;
      $display("FAIL wr_timing got busy=%b err=%b lat=%0d want busy=1 err=0 lat=1", b1, e, lat);
    end
    @(negedge clk);
    checks++;
    if ({ack[0], err[0]} !== 2'b00) begin
      errors++;
      $display("FAIL ack_one_cycle got ack=%b err=%b want 0 0", ack[0], err[0]);
    end
    access(0, 1, 1'b0, 16'h0005, 8'h00, rd, e, b1, lat);
    model(0, 1'b0, 16'h0005, 8'h00, erd, ee);
    checks++;
    if (rd !== 8'h3C || lat != 1) begin
      errors++;
      $display("FAIL raw_read got rdata=%h lat=%0d want 3c lat=1", rd, lat);
    end
  endtask

  task automatic test_alias();
    logic [15:0] ra [4] = '{16'h0005, 16'h0105, 16'h1005, 16'h00F5};
    logic [7:0]  rv [4] = '{8'h11, 8'h22, 8'h22, 8'h11};
    logic [7:0] rd, erd; logic e, ee, b1; int lat;
    access(0, 0, 1'b1, 16'h0005, 8'h11, rd, e, b1, lat);
    model(0, 1'b1, 16'h0005, 8'h11, erd, ee);
    access(0, 0, 1'b1, 16'h0105, 8'h22, rd, e, b1, lat);
    model(0, 1'b1, 16'h0105, 8'h22, erd, ee);
    for (int k = 0; k < 4; k++) begin
      access(0, 0, 1'b0, ra[k], 8'h00, rd, e, b1, lat);
      model(0, 1'b0, ra[k], 8'h00, erd, ee);
      checks++;
      if (rd !== rv[k]) begin
        errors++;
        $display("FAIL alias a=%h got %h want %h", ra[k], rd, rv[k]);
      end
    end
  endtask

  // WAIT=3: traffic driven while busy must not be accepted.
  task automatic test_wait_ignore();
    logic [7:0] exp, rd, erd; logic ee, e, b1; int lat;
    logic [15:0] a;
    a = 16'h0207;
    model(1, 1'b0, a, 8'h00, exp, ee);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = a; wdata[1] = 8'h00;
    @(negedge clk);
    lat = 0;
    while (!ack[1] && lat < 40) begin
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = lat[0] ? a : 16'h0009; wdata[1] = ~exp;
      @(negedge clk);
      lat++;
    end
    req[1] = 1'b0;
    checks++;
    if (rdata[1] !== exp || lat != 4) begin
      errors++;
      $display("FAIL wait_ignore got rdata=%h lat=%0d want %h lat=4", rdata[1], lat, exp);
    end
    access(1, 0, 1'b0, a, 8'h00, rd, e, b1, lat);
    model(1, 1'b0, a, 8'h00, erd, ee);
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL busy_write_dropped got %h want %h", rd, erd);
    end
    access(1, 0, 1'b0, 16'h0009, 8'h00, rd, e, b1, lat);
    model(1, 1'b0, 16'h0009, 8'h00, erd, ee);
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL busy_write_dropped_zp got %h want %h", rd, erd);
    end
  endtask

  task automatic test_protect();
    logic [7:0] rd, erd; logic e, ee, b1; int lat;
    access(0, 0, 1'b1, 16'hF002, 8'hFF, rd, e, b1, lat);
    model(0, 1'b1, 16'hF002, 8'hFF, erd, ee);
    checks++;
    if (e !== 1'b1 || ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL ro_write_err got err=%b ack=%b want 1 1", e, ack[0]);
    end
    access(0, 0, 1'b0, 16'hF002, 8'h00, rd, e, b1, lat);
    model(0, 1'b0, 16'hF002, 8'h00, erd, ee);
    checks++;
    if (rd !== erd || e !== 1'b0) begin
      errors++;
      $display("FAIL ro_read got rdata=%h err=%b want %h 0", rd, e, erd);
    end
    access(0, 0, 1'b1, 16'hE002, 8'h5A, rd, e, b1, lat);
    model(0, 1'b1, 16'hE002, 8'h5A, erd, ee);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL rw_write_err got err=%b want 0", e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, erd; logic e, ee, b1; int lat;
    access(1, 0, 1'b1, 16'h0033, 8'h7E, rd, e, b1, lat);
    model(1, 1'b1, 16'h0033, 8'h7E, erd, ee);
    access(1, 1, 1'b0, 16'h0033, 8'h00, rd, e, b1, lat);
    model(1, 1'b0, 16'h0033, 8'h00, erd, ee);
    checks++;
    if (b1 !== 1'b1 || lat != 4 || rd !== 8'h7E) begin
      errors++;
      $display("FAIL back_to_back got busy=%b lat=%0d rdata=%h want 1 4 7e", b1, lat, rd);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, erd, wd; logic e, ee, b1, w; int lat, r;
    logic [15:0] a;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        r  = $urandom_range(0, 2);
        a  = (r == 0) ? 16'($urandom_range(0, 255)) :
             (r == 1) ? 16'($urandom_range(256, 16'hEFFF)) :
                        16'($urandom_range(16'hF000, 16'hFFFF));
        w  = 1'($urandom);
        wd = 8'($urandom);
        access(d, (n != 0) && ($urandom_range(0, 1) == 1), w, a, wd, rd, e, b1, lat);
        model(d, w, a, wd, erd, ee);
        checks++;
        if (rd !== erd || e !== ee || b1 !== 1'b1 || lat != wait_of[d] + 1) begin
          errors++;
          $display("FAIL random d=%0d we=%b a=%h got rd=%h err=%b busy=%b lat=%0d want %h %b 1 %0d",
                   d, w, a, rd, e, b1, lat, erd, ee, wait_of[d] + 1);
        end
      end
    end
  endtask

  // WAIT=5: reset lands mid-access; nothing must complete or be stored.
  task automatic test_reset_abort();
    logic [7:0] rd, erd; logic e, ee, b1; int lat; int acks;
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0404; wdata[2] = ~m_main[2][4];
    @(negedge clk);                 // after edge 0
    req[2] = 1'b0;
    @(negedge clk);                 // after edge 1
    rst_n[2] = 1'b0;
    @(negedge clk);                 // after edge 2 (reset)
    checks++;
    if (busy[2] !== 1'b0 || ack[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b ack=%b want 0 0", busy[2], ack[2]);
    end
    rst_n[2] = 1'b1;
    m_rd[2] = 8'h00;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2] === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL abort_no_ack got %0d acks want 0", acks);
    end
    access(2, 0, 1'b0, 16'h0404, 8'h00, rd, e, b1, lat);
    model(2, 1'b0, 16'h0404, 8'h00, erd, ee);
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL abort_no_write got %h want %h", rd, erd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_wait_ignore();
    test_protect();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
